mux3_1_always: RTL and testbench

MUX3_1_ALWAYS -- requirements
Module: mux3_1_always

---
 rtl/mux3_1_always.sv | 79 +++++++
 tb/tb_mux3_1_always.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/mux3_1_always.sv
// 3:1 multiplexer with registered output and a toggle counter on the registered value.
// Two equivalent variants: procedural (mux3_1_always) and continuous-assignment (mux3_1_assign).

module mux3_1_always #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             D0,
    input  logic             D1,
    input  logic             D2,
    input  logic             S0,
    input  logic             S1,
    output logic             Y,
    output logic             Y_q,
    output logic             sel_hi,
    output logic [CNT_W-1:0] tog_cnt
);

    // S1 has priority: both 10 and 11 select D2.
    always_comb begin
        Y = D0;
        case ({S1, S0})
            2'b00:   Y = D0;
            2'b01:   Y = D1;
            default: Y = D2;
        endcase
    end

    always_comb begin
        sel_hi = S1 & S0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Y_q     <= 1'b0;
            tog_cnt <= '0;
        end else begin
            Y_q <= Y;
            if (Y != Y_q) begin
                tog_cnt <= tog_cnt + CNT_W'(1);
            end
        end
    end

endmodule

module mux3_1_assign #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             D0,
    input  logic             D1,
    input  logic             D2,
    input  logic             S0,
    input  logic             S1,
    output logic             Y,
    output logic             Y_q,
    output logic             sel_hi,
    output logic [CNT_W-1:0] tog_cnt
);

    assign Y      = S1 ? D2 : (S0 ? D1 : D0);
    assign sel_hi = S1 & S0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Y_q     <= 1'b0;
            tog_cnt <= '0;
        end else begin
            Y_q <= Y;
            if (Y != Y_q) begin
                tog_cnt <= tog_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mux3_1_always.sv
// Directed bench for mux3_1_always, cross-checked against mux3_1_assign.

module tb_mux3_1_always;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic D0 = 1'b0, D1 = 1'b0, D2 = 1'b0, S0 = 1'b0, S1 = 1'b0;

    logic       y_a, yq_a, sh_a;
    logic [7:0] cnt_a;
    logic       y_b, yq_b, sh_b;
    logic [7:0] cnt_b;
    logic       y_w, yq_w, sh_w;
    logic [1:0] cnt_w;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mux3_1_always #(.CNT_W(8)) u_always (
        .clk(clk), .rst(rst), .D0(D0), .D1(D1), .D2(D2), .S0(S0), .S1(S1),
        .Y(y_a), .Y_q(yq_a), .sel_hi(sh_a), .tog_cnt(cnt_a)
    );

    mux3_1_assign #(.CNT_W(8)) u_assign (
        .clk(clk), .rst(rst), .D0(D0), .D1(D1), .D2(D2), .S0(S0), .S1(S1),
        .Y(y_b), .Y_q(yq_b), .sel_hi(sh_b), .tog_cnt(cnt_b)
    );

    mux3_1_always #(.CNT_W(2)) u_wrap (
        .clk(clk), .rst(rst), .D0(D0), .D1(D1), .D2(D2), .S0(S0), .S1(S1),
        .Y(y_w), .Y_q(yq_w), .sel_hi(sh_w), .tog_cnt(cnt_w)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_in(input logic [4:0] v);
        {D2, D1, D0, S1, S0} = v;
    endtask

    // Edge with given D0 (S=00), then sample 1 time unit after the rising edge.
    task automatic step_d0(input logic d);
        D0 = d; S0 = 1'b0; S1 = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_yq", {31'd0, yq_a}, 32'd0);
        check("rst_cnt", {24'd0, cnt_a}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [4:0] v;
    logic       exp_y;
    int         err_before;

    initial begin
        // Reset state and mux functional while reset is held.
        #2;
        check("por_yq", {31'd0, yq_a}, 32'd0);
        check("por_cnt", {24'd0, cnt_a}, 32'd0);
        check("por_cnt_w", {30'd0, cnt_w}, 32'd0);
        @(posedge clk); #1;
        check("rst_hold_cnt", {24'd0, cnt_a}, 32'd0);
        set_in(5'b010_01); #1;  // D1=1, S=01
        check("rst_y_follow", {31'd0, y_a}, 32'd1);

        // Hand-computed vectors: {D2,D1,D0}=101.
        set_in(5'b101_01); #10; check("v101_s01_y", {31'd0, y_a}, 32'd0);
        check("v101_s01_hi", {31'd0, sh_a}, 32'd0);
        set_in(5'b101_11); #10; check("v101_s11_y", {31'd0, y_a}, 32'd1);
        check("v101_s11_hi", {31'd0, sh_a}, 32'd1);
        set_in(5'b011_10); #10; check("v011_s10_y", {31'd0, y_a}, 32'd0);
        set_in(5'b110_00); #10; check("v110_s00_y", {31'd0, y_a}, 32'd0);
        set_in(5'b001_00); #10; check("v001_s00_y", {31'd0, y_a}, 32'd1);

        // Exhaustive sweep of all 32 input combinations.
        for (int i = 0; i < 32; i++) begin
            v = i[4:0];
            set_in(v);
            #10;
            case ({S1, S0})
                2'b00:   exp_y = D0;
                2'b01:   exp_y = D1;
                default: exp_y = D2;
            endcase
            check("exh_y_always", {31'd0, y_a}, {31'd0, exp_y});
            check("exh_y_assign", {31'd0, y_b}, {31'd0, exp_y});
            check("exh_hi", {31'd0, sh_a}, {31'd0, (v[1:0] == 2'b11)});
        end

        // Random equivalence between the two variants; stop at first mismatch.
        for (int i = 0; i < 99; i++) begin
            v = 5'($urandom_range(0, 31));
            set_in(v);
            #10;
            err_before = errors;
            check("eq_y", {31'd0, y_a}, {31'd0, y_b});
            check("eq_hi", {31'd0, sh_a}, {31'd0, sh_b});
            if (errors != err_before) begin
                $display("Result: errors=%0d of %0d checks", errors, checks);
                $fatal(1, "variant divergence");
            end
        end

        // Registered path: D0=1 held for 3 edges.
        pulse_reset();
        step_d0(1'b1);
        check("reg_yq1", {31'd0, yq_a}, 32'd1);
        check("reg_cnt1", {24'd0, cnt_a}, 32'd1);
        step_d0(1'b1);
        check("reg_cnt2", {24'd0, cnt_a}, 32'd1);
        step_d0(1'b1);
        check("reg_cnt3", {24'd0, cnt_a}, 32'd1);
        check("reg_eq_cnt", {24'd0, cnt_b}, 32'd1);

        // Counter wrap for CNT_W=2: 1,2,3,0,1 (8-bit copy keeps counting).
        pulse_reset();
        step_d0(1'b1); check("wrap_1", {30'd0, cnt_w}, 32'd1);
        step_d0(1'b0); check("wrap_2", {30'd0, cnt_w}, 32'd2);
        step_d0(1'b1); check("wrap_3", {30'd0, cnt_w}, 32'd3);
        step_d0(1'b0); check("wrap_0", {30'd0, cnt_w}, 32'd0);
        step_d0(1'b1); check("wrap_1b", {30'd0, cnt_w}, 32'd1);
        check("wrap_yq", {31'd0, yq_w}, 32'd1);
        check("nowrap_cnt8", {24'd0, cnt_a}, 32'd5);

        // Async reset mid-run with tog_cnt=3, Y_q=1.
        pulse_reset();
        step_d0(1'b1);
        step_d0(1'b0);
        step_d0(1'b1);
        check("pre_async_cnt", {24'd0, cnt_a}, 32'd3);
        check("pre_async_yq", {31'd0, yq_a}, 32'd1);
        #3;
        rst = 1'b1;
        #1;
        check("async_yq", {31'd0, yq_a}, 32'd0);
        check("async_cnt", {24'd0, cnt_a}, 32'd0);
        set_in(5'b010_01); #1;
        check("async_y_track", {31'd0, y_a}, 32'd1);
        set_in(5'b101_01); #1;
        check("async_y_track0", {31'd0, y_a}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step_d0(1'b0);
        check("post_rst_y0_cnt", {24'd0, cnt_a}, 32'd0);
        step_d0(1'b1);
        check("post_rst_y1_cnt", {24'd0, cnt_a}, 32'd1);
        check("post_rst_eq_yq", {31'd0, yq_b}, {31'd0, yq_a});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
